// File: rtl/pet_bus_pkg.sv
// pet_bus_pkg: slot timing constants and width defaults shared by the bus arbiter
package pet_bus_pkg;
    localparam int ADDR_WIDTH_DEF = 17;
    localparam int DATA_WIDTH_DEF = 8;
    localparam logic [3:0] PI_START = 4'd0;
    localparam logic [3:0] CPU_START = 4'd8;
    localparam logic [3:0] CPU_EN_CNT = 4'd15;
    localparam logic [2:0] OE_START = 3'd1;
    localparam logic [2:0] OE_END = 3'd6;
    localparam logic [2:0] DOE_START = 3'd1;
    localparam logic [2:0] DOE_END = 3'd6;
    localparam logic [2:0] WE_START = 3'd2;
    localparam logic [2:0] WE_END = 3'd5;
    localparam logic [2:0] RD_CAP = 3'd6;
    localparam logic [2:0] DONE_CNT = 3'd7;
    function automatic logic in_win(input logic [2:0] p, input logic [2:0] lo, input logic [2:0] hi);
        return p >= lo && p <= hi;
    endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a level crossing into the clk domain
// ports: clk, reset (async, active-high), d (async in), q (synchronized out)
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic s1;
    always_ff @(posedge clk or posedge reset)
        if (reset) {q, s1} <= 2'b00;
        else {q, s1} <= {s1, d};
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: time-slices one RAM between a Pi port (counts 0-7) and a CPU port (counts 8-15)
// ports: pi_* request/handshake side, cpu_* side with cpu_en clock enable, ram_* SRAM side
// strobes are registered from next-cycle state so the RAM sees glitch-free enables
import pet_bus_pkg::*;
module bus_arbiter #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pi_addr,
    input  logic [DATA_WIDTH-1:0] pi_data,
    input  logic                  pi_rw_b,
    input  logic                  pi_pending,
    output logic                  pi_done,
    output logic [DATA_WIDTH-1:0] pi_rd_data,
    input  logic [15:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data,
    input  logic                  cpu_rw_b,
    output logic [DATA_WIDTH-1:0] cpu_rd_data,
    output logic                  cpu_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  ram_oe_b,
    output logic                  ram_we_b,
    output logic                  ram_data_oe
);
    logic [3:0] cnt, cnt_n;
    logic [2:0] p_n;
    logic pend_s, act, rw, act_n, rw_n, go;
    sync2 u_sync (.clk(clk), .reset(reset), .d(pi_pending), .q(pend_s));
    // act/rw describe the access owning the current slot; the Pi slot is only owned when a fresh request is seen at its start
    always_comb begin
        cnt_n = cnt + 4'd1;
        p_n = cnt_n[2:0];
        go = cnt == PI_START && pend_s && !pi_done;
        act_n = cnt == PI_START ? go : cnt == CPU_START ? 1'b1 : act;
        rw_n = cnt == PI_START ? pi_rw_b : cnt == CPU_START ? cpu_rw_b : rw;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            act <= 1'b0;
            rw <= 1'b1;
            ram_addr <= '0;
            ram_wr_data <= '0;
            ram_oe_b <= 1'b1;
            ram_we_b <= 1'b1;
            ram_data_oe <= 1'b0;
            cpu_en <= 1'b0;
            pi_rd_data <= '0;
            cpu_rd_data <= '0;
            pi_done <= 1'b0;
        end else begin
            cnt <= cnt_n;
            act <= act_n;
            rw <= rw_n;
            if (go) begin
                ram_addr <= pi_addr;
                ram_wr_data <= pi_data;
            end else if (cnt == CPU_START) begin
                ram_addr <= ADDR_WIDTH'(cpu_addr);
                ram_wr_data <= cpu_wr_data;
            end
            ram_oe_b <= !(act_n && rw_n && in_win(p_n, OE_START, OE_END));
            ram_we_b <= !(act_n && !rw_n && in_win(p_n, WE_START, WE_END));
            ram_data_oe <= act_n && !rw_n && in_win(p_n, DOE_START, DOE_END);
            cpu_en <= cnt_n == CPU_EN_CNT;
            if (act && rw && cnt == {1'b0, RD_CAP}) pi_rd_data <= ram_rd_data;
            if (act && rw && cnt == {1'b1, RD_CAP}) cpu_rd_data <= ram_rd_data;
            // set wins over clear so a request withdrawn mid-access still sees a one-clk acknowledge
            if (act && cnt == {1'b0, DONE_CNT}) pi_done <= 1'b1;
            else if (!pend_s) pi_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench with a slot-level reference model and RAM model
module tb_bus_arbiter;
    localparam int AW = 17;
    localparam int DW = 8;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          rw;
    } acc_t;
    logic clk = 1'b0, reset = 1'b1;
    logic [AW-1:0] pi_addr = '0;
    logic [DW-1:0] pi_data = '0;
    logic pi_rw_b = 1'b1, pi_pending = 1'b0, pi_done;
    logic [DW-1:0] pi_rd_data, cpu_rd_data, ram_wr_data, ram_rd_data;
    logic [15:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wr_data = '0;
    logic cpu_rw_b = 1'b1, cpu_en;
    logic [AW-1:0] ram_addr;
    logic ram_oe_b, ram_we_b, ram_data_oe;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] refmem [0:(1<<AW)-1];
    acc_t pi_q[$], cpu_q[$], cur;
    logic cur_valid = 1'b0, cur_pi = 1'b0, done_exp = 1'b0;
    logic [DW-1:0] cur_rd;
    logic [2:0] p;
    logic [3:0] tcnt;
    int checks = 0, fails = 0;

    bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .pi_addr(pi_addr), .pi_data(pi_data), .pi_rw_b(pi_rw_b), .pi_pending(pi_pending),
        .pi_done(pi_done), .pi_rd_data(pi_rd_data),
        .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_rw_b(cpu_rw_b),
        .cpu_rd_data(cpu_rd_data), .cpu_en(cpu_en),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
        .ram_oe_b(ram_oe_b), .ram_we_b(ram_we_b), .ram_data_oe(ram_data_oe)
    );

    always #5 clk = ~clk;
    assign ram_rd_data = mem[ram_addr];
    always @(negedge clk) if (!reset && !ram_we_b) mem[ram_addr] <= ram_wr_data;
    // wall-clock slot position: 0 in reset, then one step per clk
    always @(posedge clk or posedge reset) if (reset) tcnt <= '0; else tcnt <= tcnt + 4'd1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (cur_valid && cur_pi) pi_q.push_front(cur);
            cur_valid = 1'b0;
            done_exp = 1'b0;
            cpu_q.delete();
            chk("reset_oe_b", ram_oe_b, 1);
            chk("reset_we_b", ram_we_b, 1);
            chk("reset_data_oe", ram_data_oe, 0);
            chk("reset_addr", ram_addr, 0);
            chk("reset_wr_data", ram_wr_data, 0);
            chk("reset_pi_done", pi_done, 0);
            chk("reset_pi_rd", pi_rd_data, 0);
            chk("reset_cpu_rd", cpu_rd_data, 0);
            chk("reset_cpu_en", cpu_en, 0);
        end else begin
            p = tcnt[2:0];
            chk("cpu_en", cpu_en, tcnt == 4'd15);
            chk("we_oe_overlap", !ram_we_b && !ram_oe_b, 0);
            chk("doe_oe_overlap", ram_data_oe && !ram_oe_b, 0);
            if (tcnt == 4'd8 && done_exp) begin
                chk("pi_done_set", pi_done, 1);
                done_exp = 1'b0;
            end
            if (p == 3'd1 && (tcnt[3] || !ram_oe_b || ram_data_oe)) begin
                if (tcnt[3]) begin
                    chk("cpu_expected_present", cpu_q.size() > 0, 1);
                    if (cpu_q.size() > 0) begin
                        cur = cpu_q.pop_front();
                        cur_valid = 1'b1;
                    end
                end else begin
                    chk("pi_expected_present", pi_q.size() > 0, 1);
                    if (pi_q.size() > 0) begin
                        cur = pi_q.pop_front();
                        cur_valid = 1'b1;
                    end
                end
                cur_pi = !tcnt[3];
                cur_rd = refmem[cur.addr];
            end
            if (cur_valid) begin
                chk("oe_b", ram_oe_b, !(cur.rw && p >= 3'd1 && p <= 3'd6));
                chk("we_b", ram_we_b, !(!cur.rw && p >= 3'd2 && p <= 3'd5));
                chk("data_oe", ram_data_oe, !cur.rw && p >= 3'd1 && p <= 3'd6);
                chk("addr", ram_addr, cur.addr);
                if (!cur.rw) chk("wr_data", ram_wr_data, cur.data);
                if (p == 3'd7) begin
                    if (cur.rw && cur_pi) chk("pi_rd_data", pi_rd_data, cur_rd);
                    if (cur.rw && !cur_pi) chk("cpu_rd_data", cpu_rd_data, cur_rd);
                    if (!cur.rw) refmem[cur.addr] = cur.data;
                    if (cur_pi) done_exp = 1'b1;
                    cur_valid = 1'b0;
                end
            end else begin
                chk("idle_oe_b", ram_oe_b, 1);
                chk("idle_we_b", ram_we_b, 1);
                chk("idle_data_oe", ram_data_oe, 0);
            end
        end
    end

    // CPU presents a new random access early in every bus cycle
    initial forever begin
        acc_t e;
        tick();
        if (!reset && tcnt == 4'd1) begin
            cpu_addr = 16'($urandom_range(0, 63));
            cpu_wr_data = DW'($urandom);
            cpu_rw_b = 1'($urandom);
            e.addr = {1'b0, cpu_addr};
            e.data = cpu_wr_data;
            e.rw = cpu_rw_b;
            cpu_q.push_back(e);
        end
    end

    task automatic pi_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw,
                          input int hold, input logic push, output int lat);
        acc_t e;
        int n;
        pi_addr = a;
        pi_data = d;
        pi_rw_b = rw;
        pi_pending = 1'b1;
        if (push) begin
            e.addr = a;
            e.data = d;
            e.rw = rw;
            pi_q.push_back(e);
        end
        lat = 0;
        while (!pi_done && lat < 64) begin
            tick();
            lat++;
        end
        chk("pi_done_timeout", pi_done, 1);
        repeat (hold) tick();
        pi_pending = 1'b0;
        n = 0;
        while (pi_done && n < 8) begin
            tick();
            n++;
        end
        chk("pi_done_clear_latency", n <= 3, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat;
        logic [AW-1:0] a;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = DW'(i) ^ 8'hA5;
            refmem[i] = DW'(i) ^ 8'hA5;
        end
        repeat (3) tick();
        reset = 1'b0;
        n = 0;
        repeat (64) begin
            @(negedge clk);
            if (cpu_en) n++;
        end
        chk("scn1_cpu_en_pulses", n, 4);
        tick();
        pi_req(17'h10000, 8'h80, 1'b0, 40, 1'b1, lat);
        chk("scn2_mem_write", mem[17'h10000], 8'h80);
        mem[17'h00123] = 8'h5A;
        refmem[17'h00123] = 8'h5A;
        pi_req(17'h00123, 8'h00, 1'b1, 0, 1'b1, lat);
        chk("scn3_pi_rd_data", pi_rd_data, 8'h5A);
        do tick(); while (tcnt != 4'd3);
        pi_req(17'h00007, 8'h3C, 1'b0, 0, 1'b1, lat);
        chk("scn4_start_next_slot", lat, 21);
        begin
            acc_t e;
            e.addr = 17'h00042;
            e.data = 8'hC3;
            e.rw = 1'b0;
            pi_addr = e.addr;
            pi_data = e.data;
            pi_rw_b = 1'b0;
            pi_pending = 1'b1;
            pi_q.push_back(e);
            n = 0;
            while (!(tcnt == 4'd3 && !ram_we_b) && n < 64) begin
                tick();
                n++;
            end
            chk("scn5_reached_write", tcnt == 4'd3 && !ram_we_b, 1);
            reset = 1'b1;
            #1;
            chk("scn5_we_b_immediate", ram_we_b, 1);
            chk("scn5_doe_immediate", ram_data_oe, 0);
            tick();
            reset = 1'b0;
            pi_req(17'h00042, 8'hC3, 1'b0, 10, 1'b0, lat);
            chk("scn5_mem_write", mem[17'h00042], 8'hC3);
        end
        repeat (220) begin
            repeat ($urandom_range(0, 20)) tick();
            a = {1'($urandom), 10'b0, 6'($urandom)};
            pi_req(a, DW'($urandom), 1'($urandom), $urandom_range(0, 5), 1'b1, lat);
        end
        repeat (20) tick();
        do tick(); while (tcnt != 4'd0);
        chk("pi_queue_drained", pi_q.size(), 0);
        for (int i = 0; i < 64; i++) begin
            chk("mem_lo", mem[i], refmem[i]);
            chk("mem_hi", mem[17'h10000 + i], refmem[17'h10000 + i]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, SHALL set the shared RAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the RAM data width.
REQ-003 clk  in  1  sole clock; one 16-clk bus cycle = one CPU cycle.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 pi_addr  in  ADDR_WIDTH  Pi request address, from pi_register, stable while pi_pending is high.
REQ-006 pi_data  in  DATA_WIDTH  Pi write data.
REQ-007 pi_rw_b  in  1  Pi direction: 1 = read, 0 = write.
REQ-008 pi_pending  in  1  Pi request level, asynchronous to clk.
REQ-009 pi_done  out  1  Pi acknowledge level.
REQ-010 pi_rd_data  out  DATA_WIDTH  data captured by the last Pi read.
REQ-011 cpu_addr  in  16  CPU address; zero-extended to ADDR_WIDTH on the RAM bus.
REQ-012 cpu_wr_data  in  DATA_WIDTH  CPU write data.
REQ-013 cpu_rw_b  in  1  CPU direction: 1 = read, 0 = write.
REQ-014 cpu_rd_data  out  DATA_WIDTH  data captured by the last CPU read.
REQ-015 cpu_en  out  1  one-clk CPU clock-enable pulse.
REQ-016 ram_addr  out  ADDR_WIDTH  RAM address.
REQ-017 ram_wr_data  out  DATA_WIDTH  RAM write data.
REQ-018 ram_rd_data  in  DATA_WIDTH  RAM read data.
REQ-019 ram_oe_b / ram_we_b  out  1 each  RAM output/write enables, active-low.
REQ-020 ram_data_oe  out  1  FPGA drives the RAM data bus when high.

Function
REQ-021 A 4-bit slot counter SHALL increment every clk and wrap 15->0; counts 0-7 form the Pi slot and counts 8-15 the CPU slot.
REQ-022 pi_pending SHALL pass through a 2-flop synchronizer before any use; the result is pend_s.
REQ-023 A Pi access SHALL start at count 0 only when pend_s=1 and pi_done=0; otherwise the Pi slot idles: ram_oe_b=1, ram_we_b=1, ram_data_oe=0.
REQ-024 A request arriving after count 0 SHALL wait for the next count 0, with worst-case start latency 16 clk plus synchronizer delay.
REQ-025 Pi access: count 0 latches ram_addr=pi_addr and ram_wr_data=pi_data; read asserts ram_oe_b=0 during counts 1-6; write asserts ram_data_oe=1 during counts 1-6 and ram_we_b=0 during counts 2-5.
REQ-026 At count 6 of a Pi read, pi_rd_data SHALL latch ram_rd_data.
REQ-027 pi_done SHALL set at count 7 of a serviced Pi slot and clear on the first clk on which pend_s=0, forming a four-phase handshake with one access per request.
REQ-028 If pi_pending falls mid-access, the access SHALL complete unaltered; pi_done sets at count 7 and clears on the next clk.
REQ-029 Every CPU slot SHALL perform one access: count 8 latches ram_addr={0,cpu_addr} and ram_wr_data; strobe timing is identical to the Pi slot offset by 8; cpu_rd_data latches at count 14 on reads.
REQ-030 cpu_en SHALL pulse high for exactly count 15, whether or not a Pi access occurred.
REQ-031 ram_we_b=0 and ram_oe_b=0 SHALL never be asserted on the same clk; ram_data_oe=1 SHALL never coincide with ram_oe_b=0.

Reset
REQ-032 While reset is high: counter=0, sync flops=0, ram_oe_b=1, ram_we_b=1, ram_data_oe=0, ram_addr=0, ram_wr_data=0, pi_done=0, pi_rd_data=0, cpu_rd_data=0, cpu_en=0.
REQ-033 Reset asserted mid-access SHALL immediately deassert all strobes; the aborted Pi request is re-serviced after reset if pi_pending is still high.

Structure
REQ-034 The package pet_bus_pkg SHALL hold the slot boundaries and strobe start/end counts as named constants, along with the ADDR_WIDTH and DATA_WIDTH defaults.
REQ-035 The 2-flop synchronizer SHALL be the sub-module sync2; all other logic stays in bus_arbiter.

Verification
REQ-036 Scenario 1: no Pi request for 64 clk -> cpu_en pulses at counts 15, 31, 47, 63; no ram_* strobe during Pi slots.
REQ-037 Scenario 2: pi_pending=1, pi_addr=17'h10000, pi_data=8'h80, pi_rw_b=0 -> ram_we_b low for counts 2-5 with ram_addr=17'h10000, ram_wr_data=8'h80; pi_done=1; exactly one write until pi_pending drops.
REQ-038 Scenario 3: Pi read of 17'h00123 with the RAM model returning 8'h5A -> pi_rd_data=8'h5A at count 7; pi_done clears within 3 clk of pi_pending=0.
REQ-039 Scenario 4: pi_pending rises at count 3 -> the access begins at the following count 0, not the current slot; the CPU access at counts 8-15 is unaffected.
REQ-040 Scenario 5: reset pulsed at count 3 of a Pi write -> ram_we_b=1 and ram_data_oe=0 in the same cycle; after release, with pi_pending held high, the write repeats once.
REQ-041 Scenario 6: random interleaved Pi/CPU traffic against a RAM model for 10k clk -> memory contents match the reference; the REQ-031 assertions never fire.
